// File: rtl/pe_array_ctrl_if.sv
// Command and buffer/array control bundle for pe_array_ctrl.
// The master drives commands; the slave (the sequencer) drives status and control strobes.
interface pe_array_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 8
);
   logic                  start;
   logic [LEN_WIDTH-1:0]  num_vectors;
   logic                  abort;
   logic                  busy;
   logic                  done;
   logic                  acc_valid;
   logic                  pe_clear;
   logic                  pe_load_en;
   logic                  pe_compute;
   logic                  a_zero;
   logic                  w_rd_en;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic                  a_rd_en;
   logic [ADDR_WIDTH-1:0] a_rd_addr;

   modport master (
      output start, num_vectors, abort,
      input  busy, done, acc_valid, pe_clear, pe_load_en, pe_compute, a_zero,
      input  w_rd_en, w_rd_addr, a_rd_en, a_rd_addr
   );

   modport slave (
      input  start, num_vectors, abort,
      output busy, done, acc_valid, pe_clear, pe_load_en, pe_compute, a_zero,
      output w_rd_en, w_rd_addr, a_rd_en, a_rd_addr
   );
endinterface

// File: rtl/pe_array_ctrl.sv
// Command sequencer for a weight-stationary ROWS x COLS pe array: clear, weight load,
// activation stream, skew drain, done. All outputs are registered.
module pe_array_ctrl #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 4,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input logic            clk,
   input logic            rst,
   pe_array_ctrl_if.slave bus
);
   localparam int unsigned DRAIN  = ROWS + COLS - 2;
   localparam int unsigned NMAX   = (1 << LEN_WIDTH) - 1;
   localparam int unsigned CMAX_A = (COLS > NMAX) ? COLS : NMAX;
   localparam int unsigned CMAX   = (CMAX_A > DRAIN) ? CMAX_A : DRAIN;
   localparam int unsigned CNT_W  = $clog2(CMAX + 1);

   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(COLS - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN);

   typedef enum logic [2:0] {StIdle, StLoad, StStream, StDrain, StDone} state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [LEN_WIDTH-1:0] n_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         n_q            <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.acc_valid  <= 1'b0;
         bus.pe_clear   <= 1'b0;
         bus.pe_load_en <= 1'b0;
         bus.pe_compute <= 1'b0;
         bus.a_zero     <= 1'b0;
         bus.w_rd_en    <= 1'b0;
         bus.w_rd_addr  <= '0;
         bus.a_rd_en    <= 1'b0;
         bus.a_rd_addr  <= '0;
      end else if (bus.abort && state_q != StIdle) begin
         // Abort flushes the pipelined load/compute strobes too, not just the FSM.
         state_q        <= StIdle;
         cnt_q          <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.acc_valid  <= 1'b0;
         bus.pe_clear   <= 1'b0;
         bus.pe_load_en <= 1'b0;
         bus.pe_compute <= 1'b0;
         bus.a_zero     <= 1'b0;
         bus.w_rd_en    <= 1'b0;
         bus.a_rd_en    <= 1'b0;
      end else begin
         bus.pe_clear   <= 1'b0;
         bus.done       <= 1'b0;
         bus.acc_valid  <= 1'b0;
         // Buffer data arrives one cycle after the read, so load_en trails w_rd_en.
         bus.pe_load_en <= bus.w_rd_en;

         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  bus.busy <= 1'b1;
                  n_q      <= bus.num_vectors;
                  cnt_q    <= '0;
                  if (bus.num_vectors == '0) begin
                     state_q       <= StDone;
                     bus.done      <= 1'b1;
                     bus.acc_valid <= 1'b1;
                  end else begin
                     state_q       <= StLoad;
                     bus.pe_clear  <= 1'b1;
                     bus.w_rd_en   <= 1'b1;
                     bus.w_rd_addr <= '0;
                  end
               end
            end

            StLoad: begin
               if (cnt_q == LOAD_LAST) begin
                  state_q       <= StStream;
                  cnt_q         <= '0;
                  bus.w_rd_en   <= 1'b0;
                  bus.a_rd_en   <= 1'b1;
                  bus.a_rd_addr <= '0;
               end else begin
                  cnt_q         <= cnt_q + CNT_W'(1);
                  bus.w_rd_addr <= bus.w_rd_addr + ADDR_WIDTH'(1);
               end
            end

            StStream: begin
               bus.pe_compute <= 1'b1;
               if (cnt_q == CNT_W'(n_q) - CNT_W'(1)) begin
                  state_q     <= StDrain;
                  cnt_q       <= '0;
                  bus.a_rd_en <= 1'b0;
               end else begin
                  cnt_q         <= cnt_q + CNT_W'(1);
                  bus.a_rd_addr <= bus.a_rd_addr + ADDR_WIDTH'(1);
               end
            end

            // First drain cycle still computes on the last real vector; the rest feed zeros.
            StDrain: begin
               if (cnt_q == DRAIN_LAST) begin
                  state_q        <= StDone;
                  bus.pe_compute <= 1'b0;
                  bus.a_zero     <= 1'b0;
                  bus.done       <= 1'b1;
                  bus.acc_valid  <= 1'b1;
               end else begin
                  bus.a_zero <= 1'b1;
                  cnt_q      <= cnt_q + CNT_W'(1);
               end
            end

            StDone: begin
               state_q  <= StIdle;
               bus.busy <= 1'b0;
            end

            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench for pe_array_ctrl: per-cycle comparison against a timeline model
// that tracks only the cycle index since the accepted start and the vector count.
module tb_pe_array_ctrl;
   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;
   localparam int unsigned AW   = 8;
   localparam int unsigned LW   = 8;
   localparam int          D    = ROWS + COLS - 2;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          acc_valid;
      logic          pe_clear;
      logic          pe_load_en;
      logic          pe_compute;
      logic          a_zero;
      logic          w_rd_en;
      logic [AW-1:0] w_rd_addr;
      logic          a_rd_en;
      logic [AW-1:0] a_rd_addr;
   } outs_t;

   logic clk = 1'b0;
   logic rst;

   pe_array_ctrl_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   pe_array_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: active command, current cycle index (1 = first busy cycle), length.
   bit m_active = 0;
   int m_k      = 0;
   int m_n      = 0;

   function automatic int last_cycle(input int n);
      return (n == 0) ? 1 : COLS + n + D + 2;
   endfunction

   function automatic outs_t model_exp();
      outs_t e;
      int    k;
      e = '0;
      k = m_k;
      if (m_active) begin
         e.busy = 1'b1;
         if (m_n == 0) begin
            e.done      = (k == 1);
            e.acc_valid = (k == 1);
         end else begin
            e.pe_clear   = (k == 1);
            e.w_rd_en    = (k >= 1) && (k <= COLS);
            e.w_rd_addr  = e.w_rd_en ? AW'(k - 1) : '0;
            e.pe_load_en = (k >= 2) && (k <= COLS + 1);
            e.a_rd_en    = (k >= COLS + 1) && (k <= COLS + m_n);
            e.a_rd_addr  = e.a_rd_en ? AW'(k - COLS - 1) : '0;
            e.pe_compute = (k >= COLS + 2) && (k <= COLS + m_n + D + 1);
            e.a_zero     = (k >= COLS + m_n + 2) && (k <= COLS + m_n + D + 1);
            e.done       = (k == last_cycle(m_n));
            e.acc_valid  = e.done;
         end
      end
      return e;
   endfunction

   function automatic outs_t raw_sample();
      outs_t g;
      g.busy       = bus.busy;
      g.done       = bus.done;
      g.acc_valid  = bus.acc_valid;
      g.pe_clear   = bus.pe_clear;
      g.pe_load_en = bus.pe_load_en;
      g.pe_compute = bus.pe_compute;
      g.a_zero     = bus.a_zero;
      g.w_rd_en    = bus.w_rd_en;
      g.w_rd_addr  = bus.w_rd_addr;
      g.a_rd_en    = bus.a_rd_en;
      g.a_rd_addr  = bus.a_rd_addr;
      return g;
   endfunction

   // Addresses only matter while their read enable is high.
   function automatic outs_t sample();
      outs_t g;
      g = raw_sample();
      if (!g.w_rd_en) g.w_rd_addr = '0;
      if (!g.a_rd_en) g.a_rd_addr = '0;
      return g;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) m_active = 0;
      else if (m_active) begin
         if (bus.abort || m_k == last_cycle(m_n)) m_active = 0;
         else m_k++;
      end else if (bus.start) begin
         m_active = 1;
         m_k      = 1;
         m_n      = int'(bus.num_vectors);
      end
      #1;
   endtask

   task automatic drive(input logic s, input int n, input logic a);
      bus.start       = s;
      bus.num_vectors = LW'(n);
      bus.abort       = a;
   endtask

   task automatic test_reset();
      outs_t g, e;
      rst = 1'b1;
      drive(1'b0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      g = raw_sample();
      n_checks++;
      if (g !== '0) $display("FAIL reset_outputs: got %h expected 0", g);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      m_active = 0;
      tick();
      g = sample();
      e = model_exp();
      n_checks++;
      if (g !== e) $display("FAIL reset_idle: got %h expected %h", g, e);
      else n_pass++;
   endtask

   task automatic test_timeline_n3();
      outs_t g, e;
      int    done_at;
      done_at = -1;
      for (int c = 0; c < 17; c++) begin
         drive(c == 0, 3, 1'b0);
         tick();
         g = sample();
         e = model_exp();
         if (g.done) done_at = c + 1;
         n_checks++;
         if (g !== e) $display("FAIL n3_cycle%0d: got %h expected %h", c + 1, g, e);
         else n_pass++;
      end
      n_checks++;
      if (done_at != 15) $display("FAIL n3_done_cycle: got %0d expected 15", done_at);
      else n_pass++;
   endtask

   task automatic test_zero_len();
      outs_t g, e;
      for (int c = 0; c < 4; c++) begin
         drive(c == 0, 0, 1'b0);
         tick();
         g = sample();
         e = model_exp();
         n_checks++;
         if (g !== e) $display("FAIL n0_cycle%0d: got %h expected %h", c + 1, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      outs_t g, e;
      int    dut_dones, exp_dones;
      dut_dones = 0;
      exp_dones = 0;
      for (int c = 0; c < 45; c++) begin
         drive(1'b1, 1, 1'b0);
         tick();
         g = sample();
         e = model_exp();
         dut_dones += int'(g.done);
         exp_dones += int'(e.done);
         n_checks++;
         if (g !== e) $display("FAIL b2b_cycle%0d: got %h expected %h", c + 1, g, e);
         else n_pass++;
      end
      drive(1'b0, 0, 1'b0);
      n_checks++;
      if (dut_dones != 3 || exp_dones != 3)
         $display("FAIL b2b_done_count: got %0d expected 3", dut_dones);
      else n_pass++;
      repeat (15) tick();
   endtask

   task automatic test_abort();
      outs_t g, e;
      for (int c = 0; c < 26; c++) begin
         drive(c == 0 || c == 8, 3, c == 7);
         tick();
         g = sample();
         e = model_exp();
         n_checks++;
         if (g !== e) $display("FAIL abort_cycle%0d: got %h expected %h", c + 1, g, e);
         else n_pass++;
         if (c + 1 == 8) begin
            n_checks++;
            if (g.busy !== 1'b0 || g.done !== 1'b0 || g.pe_compute !== 1'b0)
               $display("FAIL abort_flush: got busy=%b done=%b compute=%b expected 0 0 0",
                        g.busy, g.done, g.pe_compute);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      outs_t g, e;
      for (int c = 0; c < COLS + 2; c++) begin
         drive(c == 0, 5, 1'b0);
         tick();
      end
      #2 rst = 1'b1;
      #1;
      g = raw_sample();
      n_checks++;
      if (g !== '0) $display("FAIL midreset_outputs: got %h expected 0", g);
      else n_pass++;
      @(posedge clk);
      #3 rst = 1'b0;
      m_active = 0;
      for (int c = 0; c < 16; c++) begin
         drive(c == 0, 2, 1'b0);
         tick();
         g = sample();
         e = model_exp();
         n_checks++;
         if (g !== e) $display("FAIL midreset_cycle%0d: got %h expected %h", c + 1, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_max_len();
      outs_t g, e;
      int    rd_cycles, done_at, last_addr, errs;
      rd_cycles = 0;
      done_at   = -1;
      last_addr = -1;
      errs      = 0;
      for (int c = 0; c < COLS + 255 + D + 4; c++) begin
         drive(c == 0, 255, 1'b0);
         tick();
         g = sample();
         e = model_exp();
         if (g.a_rd_en) begin
            rd_cycles++;
            last_addr = int'(g.a_rd_addr);
         end
         if (g.done) done_at = c + 1;
         if (g !== e) begin
            if (errs < 4) $display("FAIL max_cycle%0d: got %h expected %h", c + 1, g, e);
            errs++;
         end
      end
      n_checks++;
      if (errs != 0) $display("FAIL max_timeline: got %0d bad cycles expected 0", errs);
      else n_pass++;
      n_checks++;
      if (rd_cycles != 255) $display("FAIL max_rd_count: got %0d expected 255", rd_cycles);
      else n_pass++;
      n_checks++;
      if (last_addr != 254) $display("FAIL max_last_addr: got %0d expected 254", last_addr);
      else n_pass++;
      n_checks++;
      if (done_at != COLS + 255 + D + 2)
         $display("FAIL max_done_cycle: got %0d expected %0d", done_at, COLS + 255 + D + 2);
      else n_pass++;
   endtask

   task automatic test_random();
      outs_t g, e;
      int    errs, n;
      errs = 0;
      for (int c = 0; c < 2000; c++) begin
         n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
         drive($urandom_range(0, 3) == 0, n, $urandom_range(0, 40) == 0);
         tick();
         g = sample();
         e = model_exp();
         if (g !== e || (g.pe_load_en && g.pe_compute)) begin
            if (errs < 4) $display("FAIL rand_cycle%0d: got %h expected %h", c, g, e);
            errs++;
         end
      end
      drive(1'b0, 0, 1'b0);
      n_checks++;
      if (errs != 0) $display("FAIL rand_total: got %0d bad cycles expected 0", errs);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_timeline_n3();
      test_zero_len();
      test_back_to_back();
      test_abort();
      test_reset_mid_stream();
      test_max_len();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
